// File: rtl/button_repeat_pkg.sv
// ---------------------------------------------------------------------------
// btn_pkg: shared types and constants for the button_repeat block.
//   btn_state_t   : FSM state encoding (IDLE / WAIT / REPEAT)
//   HOLD          : state used when the auto-repeat build option is off;
//                   it reuses the WAIT encoding
//   BTN_CNT_W     : width of the tick counter and of the step counter
//   BTN_STEPS_MAX : saturation value of the per-hold step counter
//   btn_sat_inc() : increment that stops at BTN_STEPS_MAX
// ---------------------------------------------------------------------------
package btn_pkg;

    localparam int BTN_CNT_W     = 8;
    localparam int BTN_STEPS_MAX = 255;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        REPEAT = 2'd2
    } btn_state_t;

    // Single held state of the build without auto-repeat.
    localparam btn_state_t HOLD = WAIT;

    function automatic logic [BTN_CNT_W-1:0] btn_sat_inc(input logic [BTN_CNT_W-1:0] v);
        if (v == BTN_CNT_W'(BTN_STEPS_MAX)) begin
            return v;
        end
        return v + BTN_CNT_W'(1);
    endfunction

endpackage

// File: rtl/button_repeat_if.sv
// ---------------------------------------------------------------------------
// button_repeat_if: signal bundle between a debouncer/driver and the
// button_repeat block.
//   pulse : sampling tick, one clk wide (driver -> block)
//   yes   : debounced button level (driver -> block)
//   step  : one-clk move strobe (block -> driver)
//   held  : button is being held (block -> driver)
//   steps : moves issued in the current hold, saturating (block -> driver)
// Modports: master = driver side, slave = button_repeat side.
// ---------------------------------------------------------------------------
interface button_repeat_if;
    import btn_pkg::*;

    logic                 pulse;
    logic                 yes;
    logic                 step;
    logic                 held;
    logic [BTN_CNT_W-1:0] steps;

    modport master (
        output pulse,
        output yes,
        input  step,
        input  held,
        input  steps
    );

    modport slave (
        input  pulse,
        input  yes,
        output step,
        output held,
        output steps
    );

endinterface

// File: rtl/button_repeat.sv
// ---------------------------------------------------------------------------
// button_repeat: turns a debounced button level into paddle-move strobes
// with typematic auto-repeat. A press gives one step immediately; holding
// gives a first repeat DELAY_TICKS sampling ticks later and then one step
// every RATE_TICKS ticks. Release returns to IDLE and clears the counters.
//
// Ports:
//   clk   : system clock, rising edge
//   rst   : asynchronous reset, active low
//   bus   : button_repeat_if.slave (pulse, yes in; step, held, steps out)
//
// Parameters:
//   DELAY_TICKS : ticks from the first step to the first repeat (1..255)
//   RATE_TICKS  : ticks between repeat steps (1..255)
//
// Build option: macro BUTTON_REPEAT_EN enables auto-repeat. Without it the
// block issues exactly one step per press and steps stays at 1 until
// release; the tick counter and both parameters are then not used by the
// logic, only range-checked.
//
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module button_repeat
    import btn_pkg::*;
#(
    parameter int DELAY_TICKS = 8,
    parameter int RATE_TICKS  = 2
) (
    input  logic         clk,
    input  logic         rst,
    button_repeat_if.slave bus
);

    // Reject illegal timing parameters at elaboration.
    if (DELAY_TICKS < 1 || DELAY_TICKS > 255) begin : g_bad_delay
        $error("button_repeat: DELAY_TICKS=%0d outside 1..255", DELAY_TICKS);
    end
    if (RATE_TICKS < 1 || RATE_TICKS > 255) begin : g_bad_rate
        $error("button_repeat: RATE_TICKS=%0d outside 1..255", RATE_TICKS);
    end

    btn_state_t           state_q, state_d;
    logic                 step_q,  step_d;
    logic                 held_q,  held_d;
    logic [BTN_CNT_W-1:0] steps_q, steps_d;

`ifdef BUTTON_REPEAT_EN

    localparam logic [BTN_CNT_W-1:0] DELAY_LAST = BTN_CNT_W'(DELAY_TICKS - 1);
    localparam logic [BTN_CNT_W-1:0] RATE_LAST  = BTN_CNT_W'(RATE_TICKS - 1);

    logic [BTN_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        steps_d = steps_q;
        step_d  = 1'b0;

        case (state_q)
            IDLE: begin
                // A tick arriving on the press edge is deliberately not counted.
                if (bus.yes) begin
                    state_d = WAIT;
                    step_d  = 1'b1;
                    cnt_d   = '0;
                    steps_d = BTN_CNT_W'(1);
                end
            end
            WAIT, REPEAT: begin
                // Release takes priority over a terminal tick on the same edge.
                if (!bus.yes) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    steps_d = '0;
                end else if (bus.pulse) begin
                    if (cnt_q == ((state_q == WAIT) ? DELAY_LAST : RATE_LAST)) begin
                        state_d = REPEAT;
                        step_d  = 1'b1;
                        cnt_d   = '0;
                        steps_d = btn_sat_inc(steps_q);
                    end else begin
                        cnt_d = cnt_q + BTN_CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                steps_d = '0;
            end
        endcase

        held_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

`else

    // The tick is irrelevant without auto-repeat; keep lint quiet about it.
    logic unused_pulse;
    assign unused_pulse = bus.pulse;

    always_comb begin
        state_d = state_q;
        steps_d = steps_q;
        step_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.yes) begin
                    state_d = HOLD;
                    step_d  = 1'b1;
                    steps_d = BTN_CNT_W'(1);
                end
            end
            HOLD: begin
                if (!bus.yes) begin
                    state_d = IDLE;
                    steps_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                steps_d = '0;
            end
        endcase

        held_d = (state_d != IDLE);
    end

`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            step_q  <= 1'b0;
            held_q  <= 1'b0;
            steps_q <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            held_q  <= held_d;
            steps_q <= steps_d;
        end
    end

    assign bus.step  = step_q;
    assign bus.held  = held_q;
    assign bus.steps = steps_q;

endmodule

// File: tb/tb_button_repeat.sv
// ---------------------------------------------------------------------------
// tb_button_repeat: directed bench for button_repeat. Two instances share
// clock and reset: u_dut with default timing (8/2) and u_fast with 1/1.
// Expectations depend on whether BUTTON_REPEAT_EN is defined.
// ---------------------------------------------------------------------------
module tb_button_repeat;
    import btn_pkg::*;

`ifdef BUTTON_REPEAT_EN
    localparam bit REP_EN = 1'b1;
    localparam int HOLD_N = 20;
`else
    localparam bit REP_EN = 1'b0;
    localparam int HOLD_N = 50;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    button_repeat_if bus0();
    button_repeat_if bus1();

    button_repeat u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    button_repeat #(
        .DELAY_TICKS (1),
        .RATE_TICKS  (1)
    ) u_fast (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    int   errors = 0;
    int   checks = 0;
    int   seen0  = 0;
    int   seen1  = 0;
    logic prev0  = 1'b0;
    logic prev1  = 1'b0;
    logic ls0, ls1;
    logic [7:0] ls_steps0, ls_steps1;

    // One clock: drive the selected bus, sample #1 after the edge, count
    // strobes and flag any strobe that lasts two cycles.
    task automatic cyc(input logic y, input logic p, input bit sel);
        bus0.yes   = sel ? 1'b0 : y;
        bus0.pulse = sel ? 1'b0 : p;
        bus1.yes   = sel ? y : 1'b0;
        bus1.pulse = sel ? p : 1'b0;
        @(posedge clk);
        #1;
        if (bus0.step === 1'b1) seen0++;
        if (bus1.step === 1'b1) seen1++;
        if (prev0) begin
            checks++;
            if (bus0.step !== 1'b0) begin errors++; $display("FAIL step0_double: got %b expected 0", bus0.step); end
        end
        if (prev1) begin
            checks++;
            if (bus1.step !== 1'b0) begin errors++; $display("FAIL step1_double: got %b expected 0", bus1.step); end
        end
        prev0 = bus0.step;
        prev1 = bus1.step;
    endtask

    // One sampling tick followed by two quiet clocks; values seen right
    // after the tick edge are kept in ls*.
    task automatic pulse_tick(input logic y, input bit sel);
        cyc(y, 1'b1, sel);
        ls0 = bus0.step; ls_steps0 = bus0.steps;
        ls1 = bus1.step; ls_steps1 = bus1.steps;
        cyc(y, 1'b0, sel);
        cyc(y, 1'b0, sel);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        bus0.yes = 1'b1; bus0.pulse = 1'b0;
        bus1.yes = 1'b0; bus1.pulse = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus0.step !== 1'b0)  begin errors++; $display("FAIL rst_step: got %b expected 0", bus0.step); end
        checks++; if (bus0.held !== 1'b0)  begin errors++; $display("FAIL rst_held: got %b expected 0", bus0.held); end
        checks++; if (bus0.steps !== 8'd0) begin errors++; $display("FAIL rst_steps: got %0d expected 0", bus0.steps); end
        rst = 1'b1;
        #1;
        checks++; if (bus0.step !== 1'b0)  begin errors++; $display("FAIL rst_release_step: got %b expected 0", bus0.step); end
        cyc(1'b1, 1'b0, 1'b0);
        checks++; if (bus0.step !== 1'b1)  begin errors++; $display("FAIL post_rst_step: got %b expected 1", bus0.step); end
        checks++; if (bus0.held !== 1'b1)  begin errors++; $display("FAIL post_rst_held: got %b expected 1", bus0.held); end
        checks++; if (bus0.steps !== 8'd1) begin errors++; $display("FAIL post_rst_steps: got %0d expected 1", bus0.steps); end
        cyc(1'b1, 1'b0, 1'b0);
        checks++; if (bus0.step !== 1'b0)  begin errors++; $display("FAIL post_rst_step2: got %b expected 0", bus0.step); end
        cyc(1'b0, 1'b0, 1'b0);
        checks++; if (bus0.held !== 1'b0)  begin errors++; $display("FAIL post_rst_rel_held: got %b expected 0", bus0.held); end
        checks++; if (bus0.steps !== 8'd0) begin errors++; $display("FAIL post_rst_rel_steps: got %0d expected 0", bus0.steps); end
        $display("test_reset done: errors=%0d", errors);
    endtask

    task automatic test_short_press;
        seen0 = 0;
        cyc(1'b1, 1'b1, 1'b0);   // press coincident with tick 0
        checks++; if (bus0.step !== 1'b1)  begin errors++; $display("FAIL short_step: got %b expected 1", bus0.step); end
        checks++; if (bus0.steps !== 8'd1) begin errors++; $display("FAIL short_steps: got %0d expected 1", bus0.steps); end
        for (int t = 1; t <= 3; t++) pulse_tick(1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        checks++; if (bus0.held !== 1'b0)  begin errors++; $display("FAIL short_rel_held: got %b expected 0", bus0.held); end
        checks++; if (bus0.steps !== 8'd0) begin errors++; $display("FAIL short_rel_steps: got %0d expected 0", bus0.steps); end
        checks++; if (seen0 !== 1)         begin errors++; $display("FAIL short_count: got %0d expected 1", seen0); end
        $display("test_short_press done: errors=%0d", errors);
    endtask

    task automatic test_hold;
        logic exp_step;
        int   exp_total;
        seen0 = 0;
        cyc(1'b1, 1'b1, 1'b0);
        for (int t = 1; t <= HOLD_N; t++) begin
            pulse_tick(1'b1, 1'b0);
            exp_step = REP_EN && (t >= 8) && (t % 2 == 0);
            checks++;
            if (ls0 !== exp_step) begin errors++; $display("FAIL hold_step_t%0d: got %b expected %b", t, ls0, exp_step); end
            checks++;
            if (bus0.held !== 1'b1) begin errors++; $display("FAIL hold_held_t%0d: got %b expected 1", t, bus0.held); end
        end
        exp_total = REP_EN ? 8 : 1;
        checks++; if (bus0.steps !== 8'(exp_total)) begin errors++; $display("FAIL hold_steps: got %0d expected %0d", bus0.steps, exp_total); end
        checks++; if (seen0 !== exp_total)          begin errors++; $display("FAIL hold_count: got %0d expected %0d", seen0, exp_total); end
        cyc(1'b0, 1'b0, 1'b0);
        checks++; if (bus0.held !== 1'b0) begin errors++; $display("FAIL hold_rel_held: got %b expected 0", bus0.held); end
        $display("test_hold done: ticks=%0d errors=%0d", HOLD_N, errors);
    endtask

    task automatic test_release_on_tick;
        seen0 = 0;
        cyc(1'b1, 1'b1, 1'b0);
        for (int t = 1; t <= 7; t++) pulse_tick(1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);   // release together with the 8th tick
        checks++; if (bus0.step !== 1'b0)  begin errors++; $display("FAIL rel8_step: got %b expected 0", bus0.step); end
        checks++; if (bus0.held !== 1'b0)  begin errors++; $display("FAIL rel8_held: got %b expected 0", bus0.held); end
        checks++; if (bus0.steps !== 8'd0) begin errors++; $display("FAIL rel8_steps: got %0d expected 0", bus0.steps); end
        cyc(1'b0, 1'b0, 1'b0);
        checks++; if (bus0.step !== 1'b0)  begin errors++; $display("FAIL rel8_step2: got %b expected 0", bus0.step); end
        checks++; if (seen0 !== 1)         begin errors++; $display("FAIL rel8_count: got %0d expected 1", seen0); end
        $display("test_release_on_tick done: errors=%0d", errors);
    endtask

    task automatic test_reset_mid_hold;
        cyc(1'b1, 1'b1, 1'b0);
        for (int t = 1; t <= 9; t++) pulse_tick(1'b1, 1'b0);
        rst = 1'b0;
        #1;
        checks++; if (bus0.held !== 1'b0)  begin errors++; $display("FAIL midrst_held: got %b expected 0", bus0.held); end
        checks++; if (bus0.steps !== 8'd0) begin errors++; $display("FAIL midrst_steps: got %0d expected 0", bus0.steps); end
        @(posedge clk);
        #1;
        checks++; if (bus0.step !== 1'b0)  begin errors++; $display("FAIL midrst_step: got %b expected 0", bus0.step); end
        rst = 1'b1;
        prev0 = 1'b0;
        cyc(1'b1, 1'b0, 1'b0);
        checks++; if (bus0.step !== 1'b1)  begin errors++; $display("FAIL midrst_repress_step: got %b expected 1", bus0.step); end
        checks++; if (bus0.steps !== 8'd1) begin errors++; $display("FAIL midrst_repress_steps: got %0d expected 1", bus0.steps); end
        cyc(1'b0, 1'b0, 1'b0);
        $display("test_reset_mid_hold done: errors=%0d", errors);
    endtask

    task automatic test_fast_saturate;
        logic       exp_step;
        logic [7:0] exp_steps;
        int         exp_total;
        seen1 = 0;
        cyc(1'b1, 1'b1, 1'b1);
        checks++; if (bus1.step !== 1'b1) begin errors++; $display("FAIL fast_press_step: got %b expected 1", bus1.step); end
        for (int t = 1; t <= 300; t++) begin
            pulse_tick(1'b1, 1'b1);
            exp_step  = REP_EN;
            exp_steps = REP_EN ? ((t + 1 > 255) ? 8'd255 : 8'(t + 1)) : 8'd1;
            checks++;
            if (ls1 !== exp_step)        begin errors++; $display("FAIL fast_step_t%0d: got %b expected %b", t, ls1, exp_step); end
            checks++;
            if (ls_steps1 !== exp_steps) begin errors++; $display("FAIL fast_steps_t%0d: got %0d expected %0d", t, ls_steps1, exp_steps); end
        end
        exp_total = REP_EN ? 301 : 1;
        checks++; if (seen1 !== exp_total) begin errors++; $display("FAIL fast_count: got %0d expected %0d", seen1, exp_total); end
        cyc(1'b0, 1'b0, 1'b1);
        checks++; if (bus1.held !== 1'b0)  begin errors++; $display("FAIL fast_rel_held: got %b expected 0", bus1.held); end
        checks++; if (bus1.steps !== 8'd0) begin errors++; $display("FAIL fast_rel_steps: got %0d expected 0", bus1.steps); end
        $display("test_fast_saturate done: errors=%0d", errors);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_short_press;
        test_hold;
        test_release_on_tick;
        test_reset_mid_hold;
        test_fast_saturate;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/button_repeat.md
# button_repeat

Converts the debounced button level from the paddle debouncers into discrete paddle-move strobes with typematic auto-repeat. It sits between each debouncer and the paddle position logic and shares the debouncer's sampling tick. A short press yields exactly one move; a sustained hold yields an initial move, then a delay, then moves at a fixed rate.

## Interface
- `DELAY_TICKS`, default 8: sampling ticks from the first step to the first repeat step. Legal range 1..255.
- `RATE_TICKS`, default 2: sampling ticks between consecutive repeat steps. Legal range 1..255.
- `clk` input, 1 bit: system clock. All state updates on the rising edge.
- `rst` input, 1 bit: reset, asynchronous, active-low.
- `pulse` input, 1 bit: sampling tick, one `clk` wide. It is the same tick the debouncers use.
- `yes` input, 1 bit: debounced button level from the debouncer. It is registered and glitch-free.
- `step` output, 1 bit: one-`clk` strobe, one per paddle move.
- `held` output, 1 bit: 1 while the FSM is in `WAIT` or `REPEAT`.
- `steps` output, 8 bits: number of steps issued in the current hold. It saturates at 255.

## Operation
- FSM states:
  - `IDLE`: button released.
  - `WAIT`: first step issued, counting toward the first repeat.
  - `REPEAT`: auto-repeating.
- Tick counter `cnt`: 8 bits, counts `pulse` ticks only.
- `IDLE`:
  - `yes`=1 → go to `WAIT`, `step`<=1, `cnt`<=0, `steps`<=1.
  - `yes`=0 → stay in `IDLE`.
- `WAIT`:
  - `yes`=0 → go to `IDLE`.
  - `pulse`=1 and `cnt`==`DELAY_TICKS`-1 → go to `REPEAT`, `step`<=1, `cnt`<=0, `steps`+1.
  - `pulse`=1 otherwise → `cnt`+1.
- `REPEAT`:
  - `yes`=0 → go to `IDLE`.
  - `pulse`=1 and `cnt`==`RATE_TICKS`-1 → `step`<=1, `cnt`<=0, `steps`+1.
  - `pulse`=1 otherwise → `cnt`+1.
- Entering `IDLE` (release) clears `cnt`, `steps` and `step` on the same edge.
- `step` defaults to 0 on every edge where it is not explicitly set. It is never high on two consecutive cycles.
- `steps` saturates at 255 and does not wrap. `step` keeps firing after saturation.

## Timing
- Reset values: `step`=0, `held`=0, `steps`=0, state=`IDLE`, `cnt`=0.
- Reset asserted mid-hold forces `IDLE` immediately, with no strobe. After deassertion with `yes` still 1, the next edge counts as a new press and gives `step`=1.
- Press latency: `step` is high in the cycle after the first edge that samples `yes`=1 in `IDLE`.
- First repeat: one clock after the `DELAY_TICKS`-th `pulse` following the press edge.
- Subsequent repeats: one clock after every `RATE_TICKS`-th `pulse`.
- Simultaneous events:
  - Press edge coincident with `pulse`: the tick is not counted.
  - Release coincident with a terminal `pulse`: release wins, no strobe.
- `held` and `steps` are registered and change on the same edge as the state.
- All outputs come directly from flops. There is no combinational input→output path.

## Configuration
- Macro: `BUTTON_REPEAT_EN`.
- Defined: full FSM as specified above.
- Undefined:
  - `WAIT`/`REPEAT` collapse to a single `HOLD` state.
  - Exactly one `step` per press, and `steps` stays at 1 until release.
  - `cnt` and both parameters are unused. Parameter legality is still checked.

## Structure
- Shared package `btn_pkg`:
  - `btn_state_t` (2-bit enum: `IDLE`, `WAIT`, `REPEAT`).
  - `BTN_CNT_W`=8.
  - `BTN_STEPS_MAX`=255.
- Elaboration check rejects `DELAY_TICKS` or `RATE_TICKS` outside 1..255.
- Single module, no sub-module: the FSM and both counters are too tightly coupled to split.

## Test plan
- Reset with `yes`=1 held, then release `rst` → `step` first high exactly one clock after the first post-reset edge; `held`=1, `steps`=1.
- Press for 3 ticks then release (defaults) → exactly one `step`, `steps` returns to 0 on release, `held` drops on the same edge.
- Hold for 20 ticks (defaults 8/2) → steps after ticks 0, 8, 10, 12, 14, 16, 18, 20. Total 8, `steps`=8.
- Release on the same clock as the 8th `pulse` → no repeat strobe, `IDLE` next cycle.
- `DELAY_TICKS`=1, `RATE_TICKS`=1, hold 300 ticks → `step` on every tick after the press; `steps` saturates at 255, `step` keeps firing.
- Build without `BUTTON_REPEAT_EN`, hold 50 ticks → exactly one `step`, `steps`=1 throughout.
